// File: rtl/pwr_gated_alu.sv
// Power-gated ALU: a small power FSM (OFF/WAKE/ON/DRAIN/SLEEP) with output isolation
// wrapped around a single-cycle ALU and an iterative shift-add multiplier.
module pwr_gated_alu #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      PWRUP_CYCLES = 4,
  parameter logic [WIDTH-1:0] CLAMP_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_req,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             pwr_on,
  output logic             iso_active,
  output logic [2:0]       pwr_state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_WAKE  = 3'd1,
    S_ON    = 3'd2,
    S_DRAIN = 3'd3,
    S_SLEEP = 3'd4
  } pwr_state_e;

  localparam int SH = $clog2(WIDTH);
  localparam int CW = $clog2(PWRUP_CYCLES + 1);
  localparam int MW = $clog2(WIDTH);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(PWRUP_CYCLES);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7;

  pwr_state_e         state, state_next;
  logic [CW-1:0]      wake_cnt;
  logic               busy_q, done_q, err_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q, zero_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [MW-1:0]      mul_cnt_q;

  logic               accept, live_next;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  assign ready     = (state == S_ON) && !busy_q;
  assign accept    = start && ready;
  assign live_next = (state_next == S_ON) || (state_next == S_DRAIN);
  assign sum       = {1'b0, a} + {1'b0, b};
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD: {alu_carry, alu_res} = sum;
      OP_SUB: begin
        alu_res   = a - b;
        alu_carry = (a < b);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = a << b[SH-1:0];
      OP_SHR: alu_res = a >> b[SH-1:0];
      default: ;
    endcase
  end

  // A non-MUL accepted while pwr_req falls stays ON for its done cycle, then sleeps.
  always_comb begin
    state_next = state;
    case (state)
      S_OFF:   if (pwr_req) state_next = S_WAKE;
      S_WAKE: begin
        if (!pwr_req)                  state_next = S_OFF;
        else if (wake_cnt == CW'(1))   state_next = S_ON;
      end
      S_ON: begin
        if (!pwr_req) begin
          if (accept)                  state_next = (opcode == OP_MUL) ? S_DRAIN : S_ON;
          else if (busy_q && !done_q)  state_next = S_DRAIN;
          else                         state_next = S_SLEEP;
        end
      end
      S_DRAIN: begin
        if (pwr_req)                   state_next = S_ON;
        else if (done_q)               state_next = S_SLEEP;
      end
      S_SLEEP: state_next = S_OFF;
      default: state_next = S_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_OFF;
      wake_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      mul_cnt_q <= '0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (state_next == S_WAKE)
        wake_cnt <= (state == S_WAKE) ? wake_cnt - CW'(1) : WAKE_LOAD;
      else
        wake_cnt <= '0;

      if (state_next == S_OFF) begin
        // Domain is about to lose power: architectural state is gone.
        busy_q  <= 1'b0;
        res_q   <= '0;
        carry_q <= 1'b0;
        zero_q  <= 1'b0;
      end else begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            busy_q    <= 1'b1;
            acc_q     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_q   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_q  <= {1'b0, b[WIDTH-1:1]};
            mul_cnt_q <= MW'(WIDTH - 1);
          end else begin
            res_q   <= alu_res;
            carry_q <= alu_carry;
            zero_q  <= (alu_res == '0);
            done_q  <= 1'b1;
            err_q   <= opcode[3];
          end
        end else if (busy_q && done_q) begin
          busy_q <= 1'b0;
        end else if (busy_q) begin
          acc_q     <= acc_step;
          mcand_q   <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q  <= {1'b0, mplier_q[WIDTH-1:1]};
          mul_cnt_q <= mul_cnt_q - MW'(1);
          if (mul_cnt_q == MW'(1)) begin
            res_q   <= acc_step[WIDTH-1:0];
            carry_q <= |acc_step[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_step[WIDTH-1:0] == '0);
            done_q  <= 1'b1;
          end
        end
        // Rejected starts only flag an error if the domain is still live next cycle.
        if (start && !ready && live_next) err_q <= 1'b1;
      end
    end
  end

  assign iso_active = (state == S_OFF) || (state == S_WAKE) || (state == S_SLEEP);
  assign pwr_on     = (state != S_OFF);
  assign pwr_state  = state;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result     = iso_active ? CLAMP_VAL : res_q;
  assign carry      = iso_active ? 1'b0 : carry_q;
  assign zero       = iso_active ? 1'b0 : zero_q;

endmodule

// File: tb/tb_pwr_gated_alu.sv
// Directed bench for pwr_gated_alu: power sequencing, ALU ops, MUL timing,
// drain/sleep, rejected starts and reset behaviour.
module tb_pwr_gated_alu;

  logic        clk = 1'b0;
  logic        rst_n, pwr_req, start;
  logic [3:0]  opcode;
  logic [15:0] a, b, result;
  logic        carry, zero, ready, busy, done, err, pwr_on, iso_active;
  logic [2:0]  pwr_state;

  int passed = 0;
  int total  = 0;
  int busy_cnt, done_at, err_at;
  logic seen;

  pwr_gated_alu #(.WIDTH(16), .PWRUP_CYCLES(4), .CLAMP_VAL(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .start(start), .opcode(opcode),
    .a(a), .b(b), .result(result), .carry(carry), .zero(zero), .ready(ready),
    .busy(busy), .done(done), .err(err), .pwr_on(pwr_on), .iso_active(iso_active),
    .pwr_state(pwr_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, 32'(result), 32'hDEAD);
    check({tag, "_flags"}, {30'd0, carry, zero}, 32'd0);
    check({tag, "_ctl"}, {28'd0, ready, busy, done, err}, 32'd0);
    check({tag, "_pwr"}, {30'd0, pwr_on, iso_active}, 32'd1);
    check({tag, "_state"}, 32'(pwr_state), 32'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
    opcode = op; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wake_up();
    pwr_req = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; pwr_req = 1'b0; start = 1'b0; opcode = 4'd0; a = '0; b = '0;
    tick(); tick();
    check_reset_outputs("reset");

    // Power-up sequence; a start early in WAKE is silent, one in the last WAKE cycle errs in ON.
    rst_n = 1'b1;
    tick();
    pwr_req = 1'b1;
    tick();
    check("wake_pwr_on", 32'(pwr_on), 32'd1);
    check("wake_state", 32'(pwr_state), 32'd1);
    check("wake_clamp", 32'(result), 32'hDEAD);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wake_err_quiet", {30'd0, err, ready}, 32'd0);
    tick(); tick();
    check("wake_not_ready", 32'(ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("on_ready_5", {30'd0, ready, iso_active}, 32'd2);
    check("on_state", 32'(pwr_state), 32'd2);
    check("on_result_zero", 32'(result), 32'd0);
    check("wake_start_err", 32'(err), 32'd1);
    tick();
    check("err_one_cycle", 32'(err), 32'd0);

    // Single-cycle ops: {done, err, carry, zero}.
    issue(4'd0, 16'hFFFF, 16'h0001);
    check("add_res", 32'(result), 32'h0000);
    check("add_flags", {28'd0, done, err, carry, zero}, 32'b1011);
    tick();
    check("add_hold", {15'd0, done, result}, 32'h0000_0000);
    issue(4'd1, 16'h0003, 16'h0005);
    check("sub_res", 32'(result), 32'hFFFE);
    check("sub_flags", {28'd0, done, err, carry, zero}, 32'b1010);
    issue(4'd4, 16'h00F0, 16'h0FF0);
    check("xor_res", 32'(result), 32'h0F00);
    issue(4'd5, 16'h0001, 16'h0014);
    check("shl_res", 32'(result), 32'h0010);
    issue(4'd6, 16'h8000, 16'h00F3);
    check("shr_res", 32'(result), 32'h1000);
    issue(4'hA, 16'h0005, 16'h0005);
    check("inv_res", 32'(result), 32'h0000);
    check("inv_flags", {28'd0, done, err, carry, zero}, 32'b1101);

    // MUL 0x100*0x100 with a rejected start in cycle 2.
    opcode = 4'd7; a = 16'h0100; b = 16'h0100; start = 1'b1;
    busy_cnt = 0; done_at = 0; err_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = i;
      if (err && err_at == 0) err_at = i;
      start = (i == 1);
      opcode = (i == 1) ? 4'd0 : opcode;
    end
    check("mul1_busy_cycles", 32'(busy_cnt), 32'd16);
    check("mul1_done_at", 32'(done_at), 32'd16);
    check("mul1_busy_err_at", 32'(err_at), 32'd2);
    check("mul1_res", 32'(result), 32'h0000);
    check("mul1_flags", {30'd0, carry, zero}, 32'b11);

    opcode = 4'd7; a = 16'd7; b = 16'd6; start = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      start = 1'b0;
      if (done && done_at == 0) done_at = i;
    end
    check("mul2_done_at", 32'(done_at), 32'd16);
    check("mul2_res", 32'(result), 32'd42);
    check("mul2_flags", {30'd0, carry, zero}, 32'b00);

    // ADD accepted as pwr_req falls: stays ON for done, then SLEEP, OFF.
    pwr_req = 1'b0;
    issue(4'd0, 16'h0002, 16'h0003);
    check("lastop_done", {15'd0, done, result}, 32'h0001_0005);
    check("lastop_state", 32'(pwr_state), 32'd2);
    tick();
    check("lastop_sleep", {28'd0, done, pwr_state}, 32'd4);
    tick();
    check("lastop_off", 32'(pwr_state), 32'd0);

    // MUL then pwr_req drop two cycles later: DRAIN, SLEEP, OFF.
    wake_up();
    check("rewake_ready", 32'(ready), 32'd1);
    issue(4'd7, 16'd3, 16'd5);
    tick();
    pwr_req = 1'b0;
    tick();
    check("drain_state", {29'd0, pwr_state}, 32'd3);
    check("drain_pwr", {30'd0, pwr_on, iso_active}, 32'b10);
    for (int i = 4; i <= 16; i++) tick();
    check("drain_done", {15'd0, done, result}, 32'h0001_000F);
    check("drain_done_state", 32'(pwr_state), 32'd3);
    tick();
    check("sleep_state", {28'd0, done, pwr_state}, 32'd4);
    check("sleep_pwr", {14'd0, pwr_on, iso_active, result}, 32'h0003_DEAD);
    tick();
    check("off_after_sleep", {13'd0, pwr_state, result}, 32'h0000_DEAD);
    check("off_pwr", {30'd0, pwr_on, iso_active}, 32'b01);

    // Reset at MUL cycle 8.
    wake_up();
    check("wake3_res_cleared", 32'(result), 32'd0);
    issue(4'd7, 16'd3, 16'd5);
    repeat (7) tick();
    check("mul_cycle8_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    pwr_req = 1'b0;
    tick();
    check_reset_outputs("midmul_reset");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | done | busy;
    end
    check("no_done_after_reset", 32'(seen), 32'd0);

    // pwr_req dropped in WAKE cycle 2.
    pwr_req = 1'b1;
    tick();
    tick();
    check("wake2_state", 32'(pwr_state), 32'd1);
    pwr_req = 1'b0;
    tick();
    check("wake_abort_off", {29'd0, pwr_state}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | ready | pwr_on;
    end
    check("wake_abort_never_ready", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwr_gated_alu.md
PWR_GATED_ALU -- requirements
Module: pwr_gated_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width (>=4, power of two).
REQ-002 Parameter PWRUP_CYCLES, default 4, wake settling cycles (>=1).
REQ-003 Parameter CLAMP_VAL, default {WIDTH{1'b0}}, value driven on result while isolated.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pwr_req  input  1  level request for the ALU power domain to be on.
REQ-007 start  input  1  operation request, sampled each cycle.
REQ-008 opcode  input  4  operation select.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 result  output  WIDTH  last completed result, or CLAMP_VAL while isolated.
REQ-011 carry, zero  output  1 each  flags of last completed op, forced 0 while isolated.
REQ-012 ready  output  1  high when start will be accepted.
REQ-013 busy  output  1  operation in flight.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle pulse: rejected start or invalid opcode.
REQ-016 pwr_on  output  1  power-switch enable for the ALU domain.
REQ-017 iso_active  output  1  isolation clamp enable.
REQ-018 pwr_state  output  3  OFF=0, WAKE=1, ON=2, DRAIN=3, SLEEP=4.

Function
REQ-019 Power FSM, one transition per cycle max: OFF -> WAKE when pwr_req=1.
REQ-020 WAKE: load counter with PWRUP_CYCLES on entry; decrement each cycle; -> ON after exactly PWRUP_CYCLES cycles in WAKE; pwr_req=0 in WAKE -> OFF next cycle.
REQ-021 ON: pwr_req=0 and busy=0 -> SLEEP; pwr_req=0 and busy=1 -> DRAIN.
REQ-022 DRAIN: no new starts; -> SLEEP in the cycle done pulses; pwr_req re-asserted in DRAIN -> ON (op continues).
REQ-023 SLEEP: lasts exactly 1 cycle -> OFF, regardless of pwr_req.
REQ-024 pwr_on = 1 in WAKE, ON, DRAIN, SLEEP; 0 in OFF.
REQ-025 iso_active = 1 in OFF, WAKE, SLEEP; 0 in ON, DRAIN (isolation asserts before power removal, releases after settling).
REQ-026 ready = (state==ON) & ~busy.
REQ-027 start with ready=1 accepts: a, b, opcode latched that edge; start with ready=0 ignored, err pulses next cycle, no state change.
REQ-028 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by b[log2(WIDTH)-1:0], 6 SHR logical same, 7 MUL unsigned.
REQ-029 Opcodes 0-6: busy stays 0, done pulses the cycle after accept, result/flags update that same cycle.
REQ-030 MUL: iterative shift-add, busy=1 for WIDTH cycles after accept, done pulses and busy falls in cycle WIDTH after accept; result = low WIDTH bits of product.
REQ-031 carry: ADD carry-out, SUB borrow (a<b), MUL 1 if upper product bits nonzero, else 0; zero = (result==0).
REQ-032 Opcodes 8-15: accepted, result=0, zero=1, carry=0, done and err pulse together the cycle after accept.
REQ-033 result/carry/zero registers hold between ops; cleared to 0 on entry to OFF (state loss).
REQ-034 Output mux: iso_active=1 -> result=CLAMP_VAL, carry=zero=0; else register values.
REQ-035 done, err never pulse while state is OFF, WAKE or SLEEP.
REQ-036 Start accepted in the same cycle pwr_req falls: op executes; FSM -> DRAIN if MUL, else ON -> SLEEP path after done.

Reset
REQ-037 rst_n=0 at a clock edge: state OFF, counter 0, MUL in flight aborted, internal result/flags 0.
REQ-038 Outputs during/after reset: result=CLAMP_VAL, carry=zero=0, ready=busy=done=err=0, pwr_on=0, iso_active=1, pwr_state=0.
REQ-039 Reset mid-MUL or mid-WAKE: no done pulse emitted; restart requires full WAKE sequence.

Verification (WIDTH=16, PWRUP_CYCLES=4, CLAMP_VAL=16'hDEAD)
REQ-040 Reset, pwr_req=1 -> pwr_on rises 1 cycle later, ready rises exactly 5 cycles after pwr_req; result=16'hDEAD until iso_active falls, then 0.
REQ-041 ON, ADD a=16'hFFFF b=16'h0001 -> done next cycle, result=0, carry=1, zero=1; SUB a=3 b=5 -> result=16'hFFFE, carry=1.
REQ-042 MUL a=16'h0100 b=16'h0100 -> busy 16 cycles, done at cycle 16, result=0, carry=1; MUL 7*6 -> 42, carry=0.
REQ-043 MUL started, pwr_req=0 two cycles later -> DRAIN, done at cycle 16, then SLEEP 1 cycle (iso_active=1, pwr_on=1), then OFF, result=16'hDEAD.
REQ-044 start during WAKE and during busy MUL -> err pulse each, ignored; opcode 4'hA in ON -> result=0, done and err together.
REQ-045 rst_n=0 at MUL cycle 8 -> no done, all REQ-038 values next cycle; pwr_req dropped at WAKE cycle 2 -> OFF, ready never asserts.
